goldschmidt_divsqrt: RTL and testbench

Parametrised Goldschmidt divide/square-root engine with its own iteration sequencer and valid/ready handshakes on both sides. It replaces the datapath plus the separate fixed-count `div_ctrl`/`sqrt_ctrl` pair. Operand width and iteration count are parameters, and a remainder sign is produced for both division and square root. It sits in the FP divide/sqrt pipeline between mantissa normalisation and rounding.

---
 rtl/goldschmidt_divsqrt.sv | 206 ++++++++++++++++++++
 tb/tb_goldschmidt_divsqrt.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_divsqrt.sv
// goldschmidt_divsqrt
//   Goldschmidt divide / square-root engine with its own iteration
//   sequencer. Fixed-point format: LEADS integer bits, WIDTH fraction bits.
//   One SIZE x SIZE multiplier is time-shared, one product per cycle.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   in_valid/ready  operand handshake (op, n0, d0 captured on accept)
//   op              0 = n0/d0, 1 = sqrt(n0)
//   n0, d0          operands normalised to [1,2)
//   out_valid/ready result handshake
//   result          quotient or root, same format as the operands
//   r_sign          1 when the result overshoots (q*d0 > n0 or q*q > n0)
//   dbg_state_o     current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE and, with
// result/r_sign, stays stable until out_ready is seen. Neither side's ready
// depends combinationally on the other side's valid.
module goldschmidt_divsqrt #(
    parameter int LEADS = 2,
    parameter int WIDTH = 28,
    parameter int ITER  = 4,
    parameter logic [LEADS+WIDTH-1:0] K0_DIV = (LEADS+WIDTH)'(3) << (WIDTH - 2),
    // 28-bit pattern read as 0.110110101... (27 fraction bits), ~0.85355
    parameter logic [LEADS+WIDTH-1:0] K0_SQRT =
        (LEADS+WIDTH)'(((LEADS+WIDTH+28)'(28'b0110110101000001001111001101) << WIDTH) >> 27)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [LEADS+WIDTH-1:0] n0,
    input  logic [LEADS+WIDTH-1:0] d0,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEADS+WIDTH-1:0] result,
    output logic                   r_sign,
    output logic [2:0]             dbg_state_o
);
    localparam int SIZE = LEADS + WIDTH;
    localparam int PW   = 2 * SIZE;
    localparam logic [SIZE-1:0] TWO       = SIZE'(2) << WIDTH;
    localparam logic [SIZE-1:0] THREE     = SIZE'(3) << WIDTH;
    localparam logic [3:0]      ITER_LAST = 4'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ITER = 3'd2,
        S_REM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [3:0]      iter_q, iter_d;
    logic            op_q, op_d;
    logic [SIZE-1:0] n0_q, n0_d, d0_q, d0_d;
    logic [SIZE-1:0] n_q, n_d, dd_q, dd_d, k_q, k_d, t_q, t_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            r_sign_q, r_sign_d;

    logic [SIZE-1:0] mul_a, mul_b, k0, prod_t, k_new;
    logic [PW-1:0]   prod, n0_scaled;
    logic [1:0]      last_phase;

    assign k0         = op_q ? K0_SQRT : K0_DIV;
    assign last_phase = op_q ? 2'd2 : 2'd1;
    assign prod       = PW'(mul_a) * PW'(mul_b);
    assign prod_t     = prod[WIDTH+SIZE-1:WIDTH];
    // Exact correction factor from the freshly truncated D
    assign k_new      = op_q ? ((THREE - prod_t) >> 1) : (TWO - prod_t);
    assign n0_scaled  = {{LEADS{1'b0}}, n0_q, {WIDTH{1'b0}}};

    // Multiplier operand selection
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_INIT: begin
                case (phase_q)
                    2'd0: begin mul_a = k0; mul_b = n0_q; end
                    2'd1: begin
                        mul_a = k0;
                        mul_b = op_q ? K0_SQRT : d0_q;
                    end
                    default: begin mul_a = t_q; mul_b = n0_q; end
                endcase
            end
            S_ITER: begin
                case (phase_q)
                    2'd0: begin mul_a = n_q; mul_b = k_q; end
                    2'd1: begin
                        mul_a = op_q ? k_q : dd_q;
                        mul_b = k_q;
                    end
                    default: begin mul_a = dd_q; mul_b = t_q; end
                endcase
            end
            S_REM: begin
                mul_a = n_q;
                mul_b = op_q ? n_q : d0_q;
            end
            default: ;
        endcase
    end

    // Sequencer and datapath next state
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        iter_d   = iter_q;
        op_d     = op_q;
        n0_d     = n0_q;
        d0_d     = d0_q;
        n_d      = n_q;
        dd_d     = dd_q;
        k_d      = k_q;
        t_d      = t_q;
        result_d = result_q;
        r_sign_d = r_sign_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    n0_d    = n0;
                    d0_d    = d0;
                    phase_d = 2'd0;
                    iter_d  = 4'd0;
                    state_d = S_INIT;
                end
            end
            S_INIT, S_ITER: begin
                // Phase 0 always refines N; the last phase always produces
                // D and K; sqrt has an extra middle phase producing T.
                if (phase_q == 2'd0) begin
                    n_d = prod_t;
                end else if (phase_q == last_phase) begin
                    dd_d = prod_t;
                    k_d  = k_new;
                end else begin
                    t_d = prod_t;
                end
                if (phase_q == last_phase) begin
                    phase_d = 2'd0;
                    if (state_q == S_INIT) begin
                        state_d = S_ITER;
                    end else if (iter_q == ITER_LAST) begin
                        state_d = S_REM;
                    end else begin
                        iter_d = iter_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_REM: begin
                result_d = n_q;
                r_sign_d = (prod > n0_scaled);
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            iter_q   <= '0;
            op_q     <= 1'b0;
            n0_q     <= '0;
            d0_q     <= '0;
            n_q      <= '0;
            dd_q     <= '0;
            k_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            r_sign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            iter_q   <= iter_d;
            op_q     <= op_d;
            n0_q     <= n0_d;
            d0_q     <= d0_d;
            n_q      <= n_d;
            dd_q     <= dd_d;
            k_q      <= k_d;
            t_q      <= t_d;
            result_q <= result_d;
            r_sign_q <= r_sign_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign r_sign      = r_sign_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_goldschmidt_divsqrt.sv
// Testbench for goldschmidt_divsqrt: directed table on the default
// configuration plus a randomized sweep over several WIDTH/ITER instances.
module tb_goldschmidt_divsqrt;
    localparam int LEADS = 2;
    localparam int W     = 28;
    localparam int IT    = 4;
    localparam int S     = LEADS + W;
    localparam int NRAND = 1000;
    localparam int NCFG  = 6;
    localparam longint K0S_BITS = 64'h6D413CD;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int sweeps_done = 0;

    // ---------------- main DUT ----------------
    logic         m_reset, m_in_valid, m_in_ready, m_op, m_out_valid, m_out_ready, m_r_sign;
    logic [S-1:0] m_n0, m_d0, m_result;
    logic [2:0]   m_dbg;

    goldschmidt_divsqrt #(.LEADS(LEADS), .WIDTH(W), .ITER(IT)) u_dut (
        .clk(clk), .reset(m_reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .op(m_op), .n0(m_n0), .d0(m_d0), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .result(m_result), .r_sign(m_r_sign),
        .dbg_state_o(m_dbg)
    );

    // ---------------- reference model ----------------
    // Ideal Goldschmidt convergence: divide leaves N = q*(1-e) with e squaring
    // each iteration; sqrt leaves N = sqrt(x)*sqrt(1-e) with
    // e' = 3/4 e^2 + 1/4 e^3. Truncation noise is covered by model_tol.
    function automatic real model_res(input bit op, input longint n0, input longint d0,
                                      input int w, input int iter);
        real sc, x, d, k0, e;
        sc = 2.0 ** w;
        x  = real'(n0) / sc;
        d  = real'(d0) / sc;
        if (!op) begin
            e = 1.0 - 0.75 * d;
            for (int i = 0; i < iter; i++) e = e * e;
            return (x / d) * (1.0 - e) * sc;
        end
        k0 = $floor(real'(K0S_BITS) * (2.0 ** (w - 27))) / sc;
        e  = 1.0 - k0 * k0 * x;
        for (int i = 0; i < iter; i++) e = 0.75 * e * e + 0.25 * e * e * e;
        return $sqrt(x * (1.0 - e)) * sc;
    endfunction

    function automatic real model_tol(input int iter);
        return real'(3 * iter + 8);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_eq(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_near(input string name, input longint got, input real exp, input real tol);
        real err;
        checks++;
        err = real'(got) - exp;
        if (err < 0.0) err = -err;
        if (err > tol) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected %f within %0.1f ulp", name, got, exp, tol);
        end
    endtask

    task automatic note_sweep_done();
        sweeps_done++;
    endtask

    // ---------------- main DUT driver tasks ----------------
    // Called #1 after a rising edge with the engine idle.
    task automatic run_main(input bit op, input logic [S-1:0] n, input logic [S-1:0] d,
                            output int lat, output logic [S-1:0] res, output logic rs);
        m_op = op; m_n0 = n; m_d0 = d; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        m_n0 = S'($urandom);
        m_d0 = S'($urandom);
        m_op = ~op;
        lat = 0;
        while (!m_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = m_result;
        rs  = m_r_sign;
    endtask

    task automatic release_main();
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_out_ready = 1'b0;
    endtask

    function automatic bit ref_sign(input bit op, input longint res, input longint n, input longint d, input int w);
        longint lhs;
        lhs = op ? res * res : res * d;
        return lhs > (n << w);
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit           op;
        logic [S-1:0] n0;
        logic [S-1:0] d0;
        int           lat;
        logic [S-1:0] ideal;
        int           tol;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int           lat;
        logic [S-1:0] res, held;
        logic         rs;
        bit           seen;

        vecs[0] = '{op: 1'b0, n0: 30'h18000000, d0: 30'h10000000, lat: 11, ideal: 30'h18000000, tol: 3};
        vecs[1] = '{op: 1'b0, n0: 30'h10000000, d0: 30'h18000000, lat: 11, ideal: 30'h0AAAAAAA, tol: 3};
        // Starting from 2.0 the initial estimate is far off, so four
        // iterations leave a few ulp of convergence error on top of truncation.
        vecs[2] = '{op: 1'b1, n0: 30'h20000000, d0: 30'h00000000, lat: 16, ideal: 30'h16A09E66, tol: 8};
        vecs[3] = '{op: 1'b1, n0: 30'h10000000, d0: 30'h3FFFFFFF, lat: 16, ideal: 30'h10000000, tol: 4};

        m_reset = 1'b1; m_in_valid = 1'b0; m_op = 1'b0;
        m_n0 = '0; m_d0 = '0; m_out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_in_ready",  m_in_ready,  1);
        check_eq("reset_out_valid", m_out_valid, 0);
        check_eq("reset_result",    m_result,    0);
        check_eq("reset_r_sign",    m_r_sign,    0);
        @(negedge clk); m_reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run_main(vecs[i].op, vecs[i].n0, vecs[i].d0, lat, res, rs);
            check_eq($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check_near($sformatf("vec%0d_result", i), res, real'(vecs[i].ideal), real'(vecs[i].tol));
            check_near($sformatf("vec%0d_model", i), res,
                       model_res(vecs[i].op, vecs[i].n0, vecs[i].d0, W, IT), model_tol(IT));
            check_eq($sformatf("vec%0d_r_sign", i), rs,
                     ref_sign(vecs[i].op, res, vecs[i].n0, vecs[i].d0, W));
            release_main();
        end

        // Backpressure: result held for 5 cycles, then released.
        run_main(1'b0, 30'h1C000000, 30'h14000000, lat, held, rs);
        check_eq("bp_latency", lat, 11);
        check_near("bp_result", held, model_res(1'b0, 30'h1C000000, 30'h14000000, W, IT), model_tol(IT));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_result",   m_result,    held);
            check_eq("bp_hold_valid",    m_out_valid, 1);
            check_eq("bp_hold_in_ready", m_in_ready,  0);
        end
        release_main();
        check_eq("bp_release_in_ready",  m_in_ready,  1);
        check_eq("bp_release_out_valid", m_out_valid, 0);
        run_main(1'b0, 30'h12345678, 30'h1ABCDEF0, lat, res, rs);
        check_eq("bp_second_latency", lat, 11);
        check_near("bp_second_result", res, model_res(1'b0, 30'h12345678, 30'h1ABCDEF0, W, IT), model_tol(IT));
        check_eq("bp_second_r_sign", rs, ref_sign(1'b0, res, 30'h12345678, 30'h1ABCDEF0, W));
        release_main();

        // Reset in the middle of a sqrt.
        m_op = 1'b1; m_n0 = 30'h1C000000; m_d0 = '0; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); m_reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", m_out_valid, 0);
        check_eq("midrst_in_ready",  m_in_ready,  1);
        check_eq("midrst_result",    m_result,    0);
        @(negedge clk); m_reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            seen = seen | m_out_valid;
        end
        check_eq("midrst_no_stale_valid", seen, 0);
        run_main(1'b0, 30'h1F000000, 30'h11000000, lat, res, rs);
        check_eq("midrst_div_latency", lat, 11);
        check_near("midrst_div_result", res, model_res(1'b0, 30'h1F000000, 30'h11000000, W, IT), model_tol(IT));
        check_eq("midrst_div_r_sign", rs, ref_sign(1'b0, res, 30'h1F000000, 30'h11000000, W));
        release_main();

        while (sweeps_done < NCFG) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- randomized sweep over configurations ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_sweep
        localparam int GW = (g < 3) ? 16 : 28;
        localparam int GI = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
        localparam int GS = LEADS + GW;

        logic          s_reset, s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready, s_r_sign;
        logic [GS-1:0] s_n0, s_d0, s_result;
        logic [2:0]    s_dbg;
        real           exp_q[$];

        goldschmidt_divsqrt #(.LEADS(LEADS), .WIDTH(GW), .ITER(GI)) u_dut (
            .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .op(s_op), .n0(s_n0), .d0(s_d0), .out_valid(s_out_valid),
            .out_ready(s_out_ready), .result(s_result), .r_sign(s_r_sign),
            .dbg_state_o(s_dbg)
        );

        initial begin
            int            lat, exp_lat;
            bit            opb;
            logic [GS-1:0] n, d;

            s_reset = 1'b1; s_in_valid = 1'b0; s_op = 1'b0;
            s_n0 = '0; s_d0 = '0; s_out_ready = 1'b0;
            @(posedge clk); #1;
            @(negedge clk); s_reset = 1'b0;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < NRAND; i++) begin
                    opb = (p == 1);
                    n = {2'b01, GW'($urandom)};
                    d = {2'b01, GW'($urandom)};
                    exp_q.push_back(model_res(opb, n, d, GW, GI));
                    exp_lat = opb ? (3 + 3 * GI + 1) : (2 + 2 * GI + 1);
                    s_op = opb; s_n0 = n; s_d0 = d; s_in_valid = 1'b1;
                    @(posedge clk); #1;
                    s_in_valid = 1'b0;
                    s_n0 = GS'($urandom);
                    s_d0 = GS'($urandom);
                    lat = 0;
                    while (!s_out_valid && lat < 100) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check_eq($sformatf("sweep_w%0d_i%0d_op%0d_latency", GW, GI, opb), lat, exp_lat);
                    check_near($sformatf("sweep_w%0d_i%0d_op%0d_result n0=0x%0h d0=0x%0h", GW, GI, opb, n, d),
                               s_result, exp_q.pop_front(), model_tol(GI));
                    check_eq($sformatf("sweep_w%0d_i%0d_op%0d_r_sign", GW, GI, opb),
                             s_r_sign, ref_sign(opb, s_result, n, d, GW));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    s_out_ready = 1'b1;
                    @(posedge clk); #1;
                    s_out_ready = 1'b0;
                end
            end
            note_sweep_done();
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, sweeps_done=%0d expected %0d", sweeps_done, NCFG);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
